// File: rtl/serial_twos_comp_lanes.sv
// ---------------------------------------------------------------------------
// serial_twos_comp_lanes
//
// Multi-lane, word-framed serial two's-complement unit. Each lane receives a
// WIDTH-bit word LSB-first, one bit per clock. A completed word moves into an
// output buffer and is re-serialised LSB-first with one of four per-word
// operations: pass, negate, absolute value or ones' complement. Input capture
// and output shifting use separate buffers, so a new word can be collected
// while the previous one drains.
//
// Parameters:
//   WIDTH  bits per word (>= 2)
//   LANES  number of parallel serial lanes sharing framing and mode
//
// Ports:
//   t_clk      clock, all state changes on the rising edge
//   r          synchronous active-high reset, highest priority
//   in_valid   i carries a valid bit this cycle (low = stall)
//   in_sof     with in_valid, marks bit 0 of a new word
//   mode       sampled with in_sof: 0 pass, 1 negate, 2 abs, 3 ones' complement
//   i          serial data, one bit per lane, LSB first
//   y          registered serial result, one bit per lane, LSB first
//   out_valid  y holds a valid result bit
//   out_sof    y holds result bit 0
//   out_eow    y holds result bit WIDTH-1
//   ovf        per-lane overflow, meaningful only while out_eow is high
//   err        one-cycle framing error pulse
// ---------------------------------------------------------------------------
module serial_twos_comp_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] i,
  output logic [LANES-1:0] y,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eow,
  output logic [LANES-1:0] ovf,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_NEG  = 2'd1,
    OP_ABS  = 2'd2,
    OP_INV  = 2'd3
  } op_t;

  // Input side: word being assembled
  logic [CW-1:0]                 cnt;
  logic                          busy_in;
  logic [LANES-1:0][WIDTH-1:0]   in_buf;
  op_t                           in_op;
  logic                          word_done;

  // Output side: word being re-serialised
  logic [LANES-1:0][WIDTH-1:0]   out_buf;
  op_t                           out_op;
  logic [CW-1:0]                 out_cnt;
  logic [CW-1:0]                 out_next;
  logic [LANES-1:0]              seen;

  // One result bit. Serial negation copies bits up to and including the
  // first 1 and inverts everything after it, so "seen" means a 1 occurred
  // in a lower bit position. Abs negates only when the sign bit is set.
  function automatic logic op_bit(input op_t op, input logic b,
                                  input logic seen_one, input logic sign);
    case (op)
      OP_PASS: return b;
      OP_NEG:  return b ^ seen_one;
      OP_ABS:  return b ^ (seen_one & sign);
      default: return ~b;
    endcase
  endfunction

  assign out_next = out_cnt + CW'(1);

  // Input capture. An in_sof always starts a fresh word; if a word was
  // already in progress it is abandoned and flagged. A non-sof bit with no
  // word in progress is dropped and flagged. word_done pulses on the edge
  // that stores the last bit, which hands the word to the output side.
  always_ff @(posedge t_clk) begin
    if (r) begin
      cnt       <= '0;
      busy_in   <= 1'b0;
      word_done <= 1'b0;
      err       <= 1'b0;
      in_buf    <= '0;
      in_op     <= OP_PASS;
    end else begin
      word_done <= 1'b0;
      err       <= 1'b0;
      if (in_valid) begin
        if (in_sof) begin
          err <= busy_in;
          for (int l = 0; l < LANES; l++) begin
            in_buf[l][0] <= i[l];
          end
          in_op   <= op_t'(mode);
          cnt     <= CW'(1);
          busy_in <= 1'b1;
        end else if (busy_in) begin
          for (int l = 0; l < LANES; l++) begin
            in_buf[l][cnt] <= i[l];
          end
          if (cnt == LAST) begin
            cnt       <= '0;
            busy_in   <= 1'b0;
            word_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  // Output serialiser. On the edge after word_done the finished word is
  // copied in and bit 0 of the result is registered onto y straight away,
  // which gives the one-cycle latency from last input bit to first output
  // bit. The next word can only complete WIDTH edges later, exactly when
  // the current one has drained, so the copy never cuts a word short.
  always_ff @(posedge t_clk) begin
    if (r) begin
      y         <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eow   <= 1'b0;
      ovf       <= '0;
      out_buf   <= '0;
      out_op    <= OP_PASS;
      out_cnt   <= '0;
      seen      <= '0;
    end else begin
      ovf <= '0;
      if (word_done) begin
        out_buf   <= in_buf;
        out_op    <= in_op;
        out_cnt   <= '0;
        out_valid <= 1'b1;
        out_sof   <= 1'b1;
        out_eow   <= 1'b0;
        for (int l = 0; l < LANES; l++) begin
          y[l]    <= op_bit(in_op, in_buf[l][0], 1'b0, in_buf[l][WIDTH-1]);
          seen[l] <= in_buf[l][0];
        end
      end else if (out_valid && !out_eow) begin
        out_cnt <= out_next;
        out_sof <= 1'b0;
        out_eow <= (out_next == LAST);
        for (int l = 0; l < LANES; l++) begin
          y[l]    <= op_bit(out_op, out_buf[l][out_next], seen[l],
                            out_buf[l][WIDTH-1]);
          seen[l] <= seen[l] | out_buf[l][out_next];
          // Only the most negative word maps onto itself under negation
          ovf[l]  <= (out_next == LAST) &&
                     ((out_op == OP_NEG) || (out_op == OP_ABS)) &&
                     (out_buf[l] == MIN_NEG);
        end
      end else begin
        y         <= '0;
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eow   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_comp_lanes.sv
// ---------------------------------------------------------------------------
// tb_serial_twos_comp_lanes
//
// Directed bench for serial_twos_comp_lanes with WIDTH=8, LANES=2. Expected
// results are computed arithmetically when a word is driven and queued; a
// negedge monitor reassembles output words and queues them for comparison.
// ---------------------------------------------------------------------------
module tb_serial_twos_comp_lanes;

  localparam int WIDTH = 8;
  localparam int LANES = 2;

  logic             t_clk = 1'b0;
  logic             r;
  logic             in_valid;
  logic             in_sof;
  logic [1:0]       mode;
  logic [LANES-1:0] i;
  logic [LANES-1:0] y;
  logic             out_valid;
  logic             out_sof;
  logic             out_eow;
  logic [LANES-1:0] ovf;
  logic             err;

  serial_twos_comp_lanes #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .t_clk(t_clk), .r(r), .in_valid(in_valid), .in_sof(in_sof),
    .mode(mode), .i(i), .y(y), .out_valid(out_valid), .out_sof(out_sof),
    .out_eow(out_eow), .ovf(ovf), .err(err)
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic [1:0] ovf;
    int         start;
  } exp_t;

  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic [1:0] ovf;
    int         start;
    bit         frame_ok;
    int         run;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int err_count = 0;
  int cyc = 0;

  // Edge counter: at a negedge, cyc is the number of the edge just passed
  always @(posedge t_clk) cyc <= cyc + 1;

  // Output monitor: rebuilds words from y, checks framing flags and counts
  // consecutive out_valid cycles and err pulses
  logic [7:0] m_r0, m_r1;
  int         m_pos = -1;
  int         m_start = 0;
  int         m_run = 0;
  bit         m_ok = 1'b0;
  obs_t       m_rec;

  always @(negedge t_clk) begin
    if (err === 1'b1) err_count++;
    if (out_valid === 1'b1) begin
      m_run++;
      if (out_sof === 1'b1) begin
        m_pos = 0;
        m_ok = 1'b1;
        m_start = cyc;
      end else begin
        m_pos++;
      end
      if (m_pos >= 0 && m_pos < 8) begin
        m_r0[m_pos] = y[0];
        m_r1[m_pos] = y[1];
      end else begin
        m_ok = 1'b0;
      end
      if (out_sof !== (m_pos == 0)) m_ok = 1'b0;
      if (out_eow !== (m_pos == 7)) m_ok = 1'b0;
      if (out_eow !== 1'b1 && ovf !== 2'b00) m_ok = 1'b0;
      if (out_eow === 1'b1) begin
        m_rec.r0 = m_r0;
        m_rec.r1 = m_r1;
        m_rec.ovf = ovf;
        m_rec.start = m_start;
        m_rec.frame_ok = m_ok;
        m_rec.run = m_run;
        obs_q.push_back(m_rec);
      end
    end else begin
      m_run = 0;
      m_pos = -1;
    end
  end

  // Reference: plain arithmetic on the whole word, returns {ovf, result}
  function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] w);
    logic [7:0] res;
    logic       o;
    case (m)
      2'd0:    res = w;
      2'd1:    res = 8'd0 - w;
      2'd2:    res = w[7] ? (8'd0 - w) : w;
      default: res = ~w;
    endcase
    o = ((m == 2'd1) || (m == 2'd2)) && (w == 8'h80);
    return {o, res};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (n) @(negedge t_clk);
  endtask

  // Drives one word; mode is only correct on the sof bit so that latching
  // is exercised. Optionally stalls before bit stall_at for stall_n cycles.
  task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [1:0] m, input int stall_at,
                               input int stall_n, input bit expect_out);
    exp_t      e;
    logic [8:0] a0, a1;
    for (int b = 0; b < 8; b++) begin
      if (b == stall_at) begin
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (stall_n) @(negedge t_clk);
      end
      in_valid = 1'b1;
      in_sof = (b == 0);
      mode = (b == 0) ? m : ~m;
      i = {w1[b], w0[b]};
      @(negedge t_clk);
    end
    if (expect_out) begin
      a0 = model(m, w0);
      a1 = model(m, w1);
      e.r0 = a0[7:0];
      e.r1 = a1[7:0];
      e.ovf = {a1[8], a0[8]};
      e.start = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic checkWord(input string tag, output int run);
    exp_t e;
    obs_t o;
    int   waited;
    waited = 0;
    run = 0;
    while (obs_q.size() == 0 && waited < 60) begin
      @(negedge t_clk);
      waited++;
    end
    n_chk++;
    assert (obs_q.size() != 0 && exp_q.size() != 0) else begin
      n_fail++;
      $error("[TB] FAIL %s.present: observed=%0d words expected=1 word",
             tag, obs_q.size());
    end
    if (obs_q.size() != 0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      run = o.run;
      checkOutput({tag, ".lane0"}, 32'(o.r0), 32'(e.r0));
      checkOutput({tag, ".lane1"}, 32'(o.r1), 32'(e.r1));
      checkOutput({tag, ".ovf"}, 32'(o.ovf), 32'(e.ovf));
      checkOutput({tag, ".start"}, o.start, e.start);
      checkOutput({tag, ".frame"}, 32'(o.frame_ok), 32'd1);
    end
  endtask

  initial begin
    int run;
    int base;
    int sa;
    int last;

    r = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    mode = 2'd0;
    i = '0;
    repeat (2) @(negedge t_clk);
    checkOutput("reset.y", 32'(y), 32'd0);
    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.out_sof", 32'(out_sof), 32'd0);
    checkOutput("reset.out_eow", 32'(out_eow), 32'd0);
    checkOutput("reset.ovf", 32'(ovf), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    r = 1'b0;
    idle(2);

    $display("[TB] negate with overflow lane");
    applyStimulus(8'h05, 8'h80, 2'd1, -1, 0, 1'b1);
    idle(1);
    checkWord("t1", run);

    $display("[TB] abs, ones' complement, pass back-to-back");
    applyStimulus(8'hF6, 8'h0A, 2'd2, -1, 0, 1'b1);
    applyStimulus(8'h3C, 8'h55, 2'd3, -1, 0, 1'b1);
    applyStimulus(8'h3C, 8'h81, 2'd0, -1, 0, 1'b1);
    idle(1);
    checkWord("t2a", run);
    checkWord("t2b", run);
    checkWord("t2c", run);

    $display("[TB] four back-to-back words");
    idle(12);
    applyStimulus(8'h80, 8'h00, 2'd1, -1, 0, 1'b1);
    applyStimulus(8'h7F, 8'hFF, 2'd0, -1, 0, 1'b1);
    applyStimulus(8'h81, 8'h7F, 2'd2, -1, 0, 1'b1);
    applyStimulus(8'h00, 8'hA5, 2'd3, -1, 0, 1'b1);
    idle(1);
    checkWord("t3a", run);
    checkWord("t3b", run);
    checkWord("t3c", run);
    checkWord("t3d", run);
    checkOutput("t3.run", run, 32);

    $display("[TB] stalled word");
    idle(4);
    sa = $urandom_range(1, 7);
    applyStimulus(8'h6D, 8'h92, 2'd1, sa, 3, 1'b1);
    idle(1);
    checkWord("t4", run);
    idle(4);
    checkOutput("t4.no_err", err_count, 0);

    $display("[TB] sof reasserted mid-word");
    base = err_count;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      in_sof = (b == 0);
      mode = 2'd2;
      i = 2'($urandom_range(0, 3));
      @(negedge t_clk);
    end
    applyStimulus(8'h01, 8'h40, 2'd1, -1, 0, 1'b1);
    idle(12);
    checkOutput("t5.err_pulses", err_count - base, 1);
    checkWord("t5", run);
    idle(12);
    checkOutput("t5.extra_words", obs_q.size(), 0);

    $display("[TB] reset during output");
    applyStimulus(8'h33, 8'h44, 2'd0, -1, 0, 1'b0);
    last = cyc;
    idle(5);
    checkOutput("t6.bit4_valid", 32'(out_valid), 32'd1);
    checkOutput("t6.bit4_edge", cyc, last + 5);
    r = 1'b1;
    @(negedge t_clk);
    r = 1'b0;
    checkOutput("t6.y", 32'(y), 32'd0);
    checkOutput("t6.out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6.out_sof", 32'(out_sof), 32'd0);
    checkOutput("t6.ovf", 32'(ovf), 32'd0);
    in_valid = 1'b1;
    in_sof = 1'b0;
    i = 2'b11;
    @(negedge t_clk);
    in_valid = 1'b0;
    checkOutput("t6.err", 32'(err), 32'd1);
    idle(1);
    checkOutput("t6.err_cleared", 32'(err), 32'd0);
    idle(12);
    checkOutput("t6.no_output", obs_q.size(), 0);
    applyStimulus(8'h80, 8'h7E, 2'd2, -1, 0, 1'b1);
    idle(1);
    checkWord("t6.fresh", run);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_twos_comp_lanes.md
Name: serial_twos_comp_lanes

Overview:
Parametrised multi-lane, word-framed serial two's-complement unit. It is the successor to the single-bit serial inverter. Each lane receives words LSB-first, one bit per clock. A completed word is double-buffered and re-serialised LSB-first with a per-word operation: pass, negate, absolute value or ones' complement. It sits between serial arithmetic stages and adds per-lane overflow detection.

Parameters:
WIDTH, 8, bits per word (min 2); bit counter is $clog2(WIDTH) wide.
LANES, 1, number of parallel serial lanes sharing framing and mode.

Ports:
t_clk  input  1  clock; all state updates on rising edge.
r  input  1  reset, synchronous, active-high.
in_valid  input  1  i carries a valid bit this cycle; low = stall, input state holds.
in_sof  input  1  with in_valid, marks bit 0 (LSB) of a new word.
mode  input  2  sampled with in_sof: 0 pass, 1 negate, 2 abs, 3 ones' complement.
i  input  LANES  serial data, one bit per lane, LSB first.
y  output  LANES  serial result, LSB first, registered.
out_valid  output  1  y holds a valid result bit.
out_sof  output  1  y holds result bit 0.
out_eow  output  1  y holds result bit WIDTH-1.
ovf  output  LANES  per-lane overflow; valid only on the out_eow cycle.
err  output  1  one-cycle pulse for a framing error.

Behaviour:
- Reset: r sampled high at an edge gives y=0, out_valid=0, out_sof=0, out_eow=0, ovf=0, err=0. It clears the input counter and word-in-progress flag, discards both buffers and aborts any word being output. r has priority over all other inputs.
- Input capture:
  - in_valid=1 with in_sof=1: bit stored at position 0, mode latched, counter set to 1.
  - in_valid=1 with in_sof=0 while a word is in progress: bit stored at the counter position, counter increments.
  - in_valid=1 with in_sof=0 and no word in progress: bit ignored, err pulses.
- Framing error: in_sof while the counter is 1..WIDTH-1 aborts the partial word, pulses err, and starts the new word at bit 0.
- Word completion: the edge that stores bit WIDTH-1 marks the word complete and clears the counter. On the next edge the word and its mode move to the output shift buffer.
- Output timing: if the last input bit is sampled at edge k, result bit n appears on y after edge k+1+n (n=0..WIDTH-1).
  - out_sof is high with bit 0; out_eow is high with bit WIDTH-1.
  - out_valid stays high for exactly WIDTH cycles per word.
  - There is no output back-pressure.
- Back-to-back words: with continuous in_valid, the next word completes exactly as the output buffer drains. out_valid stays high with no gap between words. Mode can change every word.
- Operations, per lane, on word W:
  - pass: W.
  - negate: (~W+1) mod 2^WIDTH. Implemented bit-serially: copy bits up to and including the first 1, invert every later bit.
  - abs: negate if W[WIDTH-1]=1, otherwise pass.
  - ones' complement: ~W.
- Overflow: ovf[l]=1 on the out_eow cycle only when mode is negate or abs and W=2^(WIDTH-1) (result equals W). It is 0 for W=0 and for every other word and mode.
- Stalls: in_valid=0 mid-word holds the counter. Output of a previously completed word is unaffected.
- Reset mid-word or mid-output: all partial data is lost. Output resumes only after a full new word is received.

Test Plan:
1. WIDTH=8, LANES=2, mode=1; lane0=0x05, lane1=0x80, continuous valid -> lane0 outputs 0xFB, lane1 outputs 0x80; ovf=2'b10 on out_eow. First y bit appears one cycle after the last input bit.
2. mode=2; lane0=0xF6, lane1=0x0A -> both lanes output 0x0A, ovf=0. Next word mode=3 with lane0=0x3C -> 0xC3. Next word mode=0 with lane0=0x3C -> 0x3C.
3. Four back-to-back words with mode sequence 1,0,2,3 -> out_valid high for 32 consecutive cycles, out_sof every 8 cycles, each word's result correct.
4. Word with in_valid low for 3 random cycles mid-word -> result correct; first output bit still one cycle after the last input bit.
5. in_sof reasserted at bit 3 of a word -> err pulses once; partial word produces no output; the new word 0x01 in mode 1 outputs 0xFF.
6. r asserted for one cycle during output bit 4 -> next edge y=0 and out_valid=0. A bit with in_sof=0 before any new in_sof -> err pulse. A following fresh word then processes normally.
